midi_uart_rx: RTL and testbench
===============================

MIDI_UART_RX -- requirements
Module: midi_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 48000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250: MIDI serial bit rate.
REQ-003 SHALL derive OSR_DIV = CLK_HZ/(BAUD*16), integer truncation; 96 at defaults.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port midi_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port midi_word, output, 8 bits: last correctly framed byte received.
REQ-008 SHALL have port midi_valid, output, 1 bit: one-cycle pulse when midi_word is updated.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on stop-bit failure.
REQ-010 SHALL have port rx_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 SHALL pass midi_rx through a 2-flop synchronizer, both flops set to 1 by reset; all logic uses the synchronized value only.
REQ-012 SHALL generate a sample tick every OSR_DIV clocks, i.e. 16 ticks per bit.
REQ-013 SHALL zero the tick divider and sample counter on the cycle a falling edge is detected in IDLE, so tick n falls exactly n*OSR_DIV clocks after detection.
REQ-014 SHALL number frame bits b = 0 (start), 1..8 (data, LSB first), 9 (stop); sample s (0..15) of bit b is tick b*16+s+1.
REQ-015 SHALL decide each bit by majority vote of samples 7, 8, 9 of that bit.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-017 IDLE -> START on a synchronized 1->0 transition.
REQ-018 START: vote = 1 means false start, go to IDLE with no output pulse; vote = 0 means go to DATA at the end of bit 0.
REQ-019 DATA: shift 8 voted bits LSB first, then go to STOP.
REQ-020 STOP, at sample 9 of bit 9: vote = 1 means load midi_word, pulse midi_valid on the next cycle, and enter IDLE immediately, so back-to-back frames are accepted.
REQ-021 STOP, at sample 9 of bit 9: vote = 0 means pulse frame_err, leave midi_word unchanged, no midi_valid, enter BREAK.
REQ-022 BREAK: count consecutive ticks where the line is high; any low sample clears the count; at 16 consecutive high ticks, go to IDLE.
REQ-023 midi_valid and frame_err SHALL never be high in the same cycle, and neither SHALL be high for more than one cycle per frame.
REQ-024 midi_word SHALL hold its value between midi_valid pulses.
REQ-025 SHALL filter no byte values; system real-time bytes (0xF8 to 0xFF) SHALL be output like any other byte.

Reset
REQ-026 rst SHALL force midi_word=0x00, midi_valid=0, frame_err=0, rx_busy=1, state BREAK, with all counters and the shift register cleared.
REQ-027 rst asserted mid-frame SHALL discard the partial byte; no pulse for that frame may follow.
REQ-028 After reset the receiver SHALL accept a new frame only after 16 consecutive high ticks, to prevent resync on stray data bits.

Verification (CLK_HZ=48e6, BAUD=31250, bit = 1536 clk)
REQ-029 Clean frame: after reset and 2 bit-times idle, send 0x92 -> midi_word=0x92, exactly one midi_valid, 14784 +/-4 clk after the midi_rx falling edge; frame_err=0.
REQ-030 Back-to-back, no idle gap: 0x90, 0x3C, 0x64 -> three midi_valid pulses with words 0x90, 0x3C, 0x64 in order; no frame_err.
REQ-031 Glitch: midi_rx low for 200 clk, then high -> no midi_valid, no frame_err; rx_busy returns to 0 within 1 bit-time.
REQ-032 Framing error: send 0x55 with stop bit 0, line held low 3 bit-times, then high -> one frame_err, midi_word unchanged, rx_busy=1 until 16 high ticks; a following 0xF8 is received correctly.
REQ-033 Reset mid-frame: rst for 1 cycle during data bit 4 of 0x0F -> no pulse for that frame; a following 0xFA after >= 1 idle bit-time gives midi_word=0xFA.
REQ-034 Bit-time jitter: 0xA5 sent with every bit 3% long, then repeated with every bit 3% short -> both received as 0xA5 with no frame_err.

Source files
------------

// File: rtl/midi_uart_rx.sv
// midi_uart_rx -- MIDI serial receiver (8N1, 16x oversampled).
//
// Ports:
//   clk        : system clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   midi_rx    : asynchronous serial input, idle high
//   midi_word  : last correctly framed byte
//   midi_valid : one-cycle pulse when midi_word is updated
//   frame_err  : one-cycle pulse when a stop bit is read as 0
//   rx_busy    : high whenever the receiver is not in IDLE
//
// Each bit is decided by a majority vote of samples 7, 8 and 9 of its sixteen
// sample ticks. After reset or a framing error the receiver waits for a full
// bit-time of continuous high line before it will look for a start edge again.
module midi_uart_rx #(
  parameter int CLK_HZ = 48000000,
  parameter int BAUD   = 31250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic [7:0] midi_word,
  output logic       midi_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int OSR_DIV = CLK_HZ / (BAUD * 16);
  localparam int DIV_W   = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OSR_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_prev;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_samp;
  logic [3:0]       r_bit;
  logic             r_v7;
  logic             r_v8;
  logic [7:0]       r_shift;
  logic [4:0]       r_hi_cnt;
  logic [7:0]       r_word;
  logic             r_valid;
  logic             r_err;
  logic             r_busy;

  logic w_rx;
  logic w_fall;
  logic w_tick;
  logic w_s9;
  logic w_s15;
  logic w_vote;
  logic w_load;
  logic w_err;
  logic w_busy_nxt;

  assign w_rx   = r_sync2;
  // Only a start edge seen while idle re-aligns the sampling grid.
  assign w_fall = (r_state == ST_IDLE) && r_rx_prev && !w_rx;
  assign w_tick = (r_div == DIV_LAST);
  assign w_s9   = w_tick && (r_samp == 4'd9);
  assign w_s15  = w_tick && (r_samp == 4'd15);
  // Samples 7 and 8 are held in flops; sample 9 is the live line value.
  assign w_vote = (r_v7 & r_v8) | (r_v7 & w_rx) | (r_v8 & w_rx);

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= midi_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BREAK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_nxt = ST_START;
        else        w_state_nxt = ST_IDLE;
      end
      ST_START: begin
        if (w_s9 && w_vote) w_state_nxt = ST_IDLE;
        else if (w_s15)     w_state_nxt = ST_DATA;
        else                w_state_nxt = ST_START;
      end
      ST_DATA: begin
        if (w_s15 && (r_bit == 4'd8)) w_state_nxt = ST_STOP;
        else                          w_state_nxt = ST_DATA;
      end
      ST_STOP: begin
        // Leaving at sample 9 of the stop bit lets a back-to-back start edge be caught.
        if (w_s9) w_state_nxt = w_vote ? ST_IDLE : ST_BREAK;
        else      w_state_nxt = ST_STOP;
      end
      ST_BREAK: begin
        if (w_tick && w_rx && (r_hi_cnt == 5'd15)) w_state_nxt = ST_IDLE;
        else                                       w_state_nxt = ST_BREAK;
      end
      default: w_state_nxt = ST_BREAK;
    endcase
  end

  // Output decode: frame completion events and next busy value.
  always_comb begin
    w_load = 1'b0;
    w_err  = 1'b0;
    if ((r_state == ST_STOP) && w_s9) begin
      w_load = w_vote;
      w_err  = !w_vote;
    end else begin
      w_load = 1'b0;
      w_err  = 1'b0;
    end
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Tick divider, sample/bit counters, vote samples and the break run counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      r_samp   <= 4'd0;
      r_bit    <= 4'd0;
      r_v7     <= 1'b1;
      r_v8     <= 1'b1;
      r_hi_cnt <= 5'd0;
    end else if (w_fall) begin
      r_div  <= '0;
      r_samp <= 4'd0;
      r_bit  <= 4'd0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) r_samp <= r_samp + 4'd1;
      if (w_s15 && ((r_state == ST_START) || (r_state == ST_DATA))) r_bit <= r_bit + 4'd1;
      if (w_tick && (r_samp == 4'd7)) r_v7 <= w_rx;
      if (w_tick && (r_samp == 4'd8)) r_v8 <= w_rx;
      if (r_state != ST_BREAK) r_hi_cnt <= 5'd0;
      else if (w_tick)         r_hi_cnt <= w_rx ? r_hi_cnt + 5'd1 : 5'd0;
    end
  end

  // Data shift register (LSB arrives first, so shift right).
  always_ff @(posedge clk) begin
    if (rst || w_fall) begin
      r_shift <= 8'h00;
    end else if ((r_state == ST_DATA) && w_s9) begin
      r_shift <= {w_vote, r_shift[7:1]};
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word  <= 8'h00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      if (w_load) r_word <= r_shift;
      r_valid <= w_load;
      r_err   <= w_err;
      r_busy  <= w_busy_nxt;
    end
  end

  assign midi_word  = r_word;
  assign midi_valid = r_valid;
  assign frame_err  = r_err;
  assign rx_busy    = r_busy;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Self-checking bench for midi_uart_rx. Runs at a reduced clock (16 clocks per
// sample tick) so every scenario fits a short run; timings scale with OSR.
module tb_midi_uart_rx;

  localparam int OSR    = 16;
  localparam int BAUD   = 31250;
  localparam int CLK_HZ = BAUD * 16 * OSR;
  localparam int BIT    = 16 * OSR;
  localparam int LAT    = 154 * OSR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       midi_rx = 1'b1;
  logic [7:0] midi_word;
  logic       midi_valid;
  logic       frame_err;
  logic       rx_busy;

  midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .midi_rx   (midi_rx),
    .midi_word (midi_word),
    .midi_valid(midi_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: bytes that must come out, in order, and expected error count.
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         n_seen  = 0;
  int         exp_err = 0;

  int         err_seen = 0;
  int         both_cnt = 0;
  int         dbl_cnt  = 0;
  int         hold_cnt = 0;
  logic [7:0] last_word  = 8'h00;
  logic       prev_pulse = 1'b0;
  longint     fall_t  = 0;
  longint     valid_t = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      last_word  <= 8'h00;
      prev_pulse <= 1'b0;
    end else begin
      if (midi_valid) begin
        obs_q.push_back(midi_word);
        valid_t   <= longint'($time);
        last_word <= midi_word;
      end else if (midi_word !== last_word) begin
        hold_cnt <= hold_cnt + 1;
      end
      if (frame_err) err_seen <= err_seen + 1;
      if (midi_valid && frame_err) both_cnt <= both_cnt + 1;
      if ((midi_valid || frame_err) && prev_pulse) dbl_cnt <= dbl_cnt + 1;
      prev_pulse <= midi_valid | frame_err;
    end
  end

  task automatic idle(input int n);
    @(negedge clk);
    midi_rx = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic hold_low(input int n);
    @(negedge clk);
    midi_rx = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // One 10-bit frame; rst_bit >= 0 pulses rst for one cycle mid-way through that frame bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int blen, input int rst_bit);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      midi_rx = bits[k];
      if (k == 0) fall_t = longint'($time);
      if (k == rst_bit) begin
        repeat (blen / 2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (blen - blen / 2 - 2) @(negedge clk);
      end else begin
        repeat (blen - 1) @(negedge clk);
      end
    end
    if (rst_bit < 0) begin
      if (stop) exp_q.push_back(b);
      else      exp_err++;
    end
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int k = n_seen; k < exp_q.size(); k++) begin
      if (k < obs_q.size()) check_eq({tag, "_word"}, obs_q[k], exp_q[k]);
    end
    n_seen = exp_q.size();
    check_eq({tag, "_frame_err"}, err_seen, exp_err);
  endtask

  initial begin
    longint     lat;
    logic [7:0] rb;
    int         blen;
    int         gap;

    rst = 1'b1;
    midi_rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_word",  midi_word,  8'h00);
    check_eq("rst_valid", midi_valid, 1'b0);
    check_eq("rst_ferr",  frame_err,  1'b0);
    check_eq("rst_busy",  rx_busy,    1'b1);
    @(posedge clk);
    #2 rst = 1'b0;

    // Receiver must stay busy until a full bit-time of high line has been seen.
    repeat (100) @(negedge clk);
    check_eq("post_rst_busy", rx_busy, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    check_eq("post_rst_idle", rx_busy, 1'b0);

    // Clean frame with latency measurement.
    send_frame(8'h92, 1'b1, BIT, -1);
    idle(BIT);
    check_rx("clean");
    check_eq("clean_word", midi_word, 8'h92);
    lat = (valid_t - fall_t) / 10;
    check_eq("clean_latency", ((lat >= LAT - 4) && (lat <= LAT + 4)) ? LAT : 32'(lat), LAT);

    // Back-to-back frames, no idle gap.
    send_frame(8'h90, 1'b1, BIT, -1);
    send_frame(8'h3C, 1'b1, BIT, -1);
    send_frame(8'h64, 1'b1, BIT, -1);
    idle(BIT);
    check_rx("b2b");

    // Short glitch is a false start.
    hold_low(BIT / 8);
    idle(BIT - BIT / 8);
    check_eq("glitch_busy", rx_busy, 1'b0);
    idle(BIT);
    check_rx("glitch");

    // Framing error, line low for a while, then recovery.
    send_frame(8'h55, 1'b0, BIT, -1);
    hold_low(2 * BIT);
    check_rx("ferr");
    check_eq("ferr_word_kept", midi_word, 8'h64);
    check_eq("ferr_busy_low", rx_busy, 1'b1);
    idle(8 * OSR);
    check_eq("ferr_busy_high8", rx_busy, 1'b1);
    idle(12 * OSR);
    check_eq("ferr_busy_done", rx_busy, 1'b0);
    send_frame(8'hF8, 1'b1, BIT, -1);
    idle(BIT);
    check_rx("after_ferr");

    // Reset during data bit 4 (frame bit 5) discards the frame.
    send_frame(8'h0F, 1'b1, BIT, 5);
    idle(BIT);
    check_rx("mid_rst");
    check_eq("mid_rst_word", midi_word, 8'h00);
    send_frame(8'hFA, 1'b1, BIT, -1);
    idle(BIT);
    check_rx("after_rst");
    check_eq("after_rst_word", midi_word, 8'hFA);

    // Bit-time jitter, +3% and -3%.
    send_frame(8'hA5, 1'b1, BIT + BIT * 3 / 100 + 1, -1);
    idle(BIT);
    send_frame(8'hA5, 1'b1, BIT - BIT * 3 / 100 - 1, -1);
    idle(BIT);
    check_rx("jitter");

    // Random bytes, random per-frame bit length and idle gap.
    for (int i = 0; i < 6; i++) begin
      rb   = 8'($urandom_range(0, 255));
      blen = int'($urandom_range(BIT - 8, BIT + 8));
      gap  = int'($urandom_range(0, BIT));
      send_frame(rb, 1'b1, blen, -1);
      if (gap > 0) idle(gap);
    end
    idle(2 * BIT);
    check_rx("random");

    check_eq("valid_and_ferr_overlap", both_cnt, 0);
    check_eq("pulse_longer_than_1", dbl_cnt, 0);
    check_eq("word_hold", hold_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
